// File: rtl/adc_spi_responder.sv
// adc_spi_responder
// SPI responder emulating a 2-channel, 12-bit MCP3202-style ADC in SPI mode 0.
// All bus inputs are asynchronous to clk and are resampled through a flop
// chain. The frame is then decoded from SCLK edge pulses in the clk domain.
// MISO is launched one clk cycle after each detected SCLK fall.
module adc_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adc_cs_n,
    input  logic        adc_sclk,
    input  logic        adc_din,
    output logic        adc_data_out,
    output logic        adc_data_oe,
    input  logic [11:0] ch0_value,
    input  logic [11:0] ch1_value,
    output logic        conv_valid,
    output logic [11:0] conv_data,
    output logic        conv_channel,
    output logic        conv_single,
    output logic        frame_abort
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_CMD        = 3'd2,
        ST_NULL_OUT   = 3'd3,
        ST_DATA_MSB   = 3'd4,
        ST_DATA_LSB   = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    // Sample value for a command. Differential results are computed with a
    // borrow bit so that a negative difference saturates to zero.
    function automatic logic [11:0] select_sample(
        input logic        sgl,
        input logic        odd,
        input logic [11:0] c0,
        input logic [11:0] c1
    );
        logic [12:0] diff;
        logic [11:0] res;
        diff = 13'd0;
        if (sgl) begin
            if (odd) begin
                res = c1;
            end else begin
                res = c0;
            end
        end else begin
            if (odd) begin
                diff = {1'b0, c1} - {1'b0, c0};
            end else begin
                diff = {1'b0, c0} - {1'b0, c1};
            end
            if (diff[12]) begin
                res = 12'd0;
            end else begin
                res = diff[11:0];
            end
        end
        return res;
    endfunction

    // Synchronizer chains and edge-detect history. CS resets low so that a
    // reset taken with CS held low does not look like a fresh CS fall.
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic                   cs_prev_q;
    logic                   sclk_prev_q;

    logic cs_s;
    logic sclk_s;
    logic din_s;
    logic cs_rise_s;
    logic cs_fall_s;
    logic sclk_rise_s;
    logic sclk_fall_s;

    // FSM and datapath registers
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        sgl_q, sgl_d;
    logic        odd_q, odd_d;
    logic        msbf_q, msbf_d;
    logic [11:0] sample_q, sample_d;
    logic        out_q, out_d;
    logic        oe_q, oe_d;
    logic        conv_valid_q, conv_valid_d;
    logic [11:0] conv_data_q, conv_data_d;
    logic        conv_channel_q, conv_channel_d;
    logic        conv_single_q, conv_single_d;
    logic        abort_q, abort_d;
    logic        in_frame_s;

    // Resample the asynchronous bus inputs and keep one cycle of history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q   <= '0;
            sclk_sync_q <= '0;
            din_sync_q  <= '0;
            cs_prev_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], adc_cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], adc_sclk};
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], adc_din};
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign din_s       = din_sync_q[SYNC_STAGES-1];
    assign cs_rise_s   = cs_s & ~cs_prev_q;
    assign cs_fall_s   = ~cs_s & cs_prev_q;
    assign sclk_rise_s = sclk_s & ~sclk_prev_q;
    assign sclk_fall_s = ~sclk_s & sclk_prev_q;
    assign in_frame_s  = (state_q == ST_CMD) || (state_q == ST_NULL_OUT) ||
                         (state_q == ST_DATA_MSB) || (state_q == ST_DATA_LSB);

    // State and datapath register update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 4'd0;
            last_q         <= 1'b0;
            sgl_q          <= 1'b0;
            odd_q          <= 1'b0;
            msbf_q         <= 1'b0;
            sample_q       <= 12'd0;
            out_q          <= 1'b0;
            oe_q           <= 1'b0;
            conv_valid_q   <= 1'b0;
            conv_data_q    <= 12'd0;
            conv_channel_q <= 1'b0;
            conv_single_q  <= 1'b0;
            abort_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_q         <= last_d;
            sgl_q          <= sgl_d;
            odd_q          <= odd_d;
            msbf_q         <= msbf_d;
            sample_q       <= sample_d;
            out_q          <= out_d;
            oe_q           <= oe_d;
            conv_valid_q   <= conv_valid_d;
            conv_data_q    <= conv_data_d;
            conv_channel_q <= conv_channel_d;
            conv_single_q  <= conv_single_d;
            abort_q        <= abort_d;
        end
    end

    // Frame decoder: next state, MISO launch and conversion reporting.
    // Synchronized CS high overrides any SCLK edge seen in the same cycle.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        last_d         = last_q;
        sgl_d          = sgl_q;
        odd_d          = odd_q;
        msbf_d         = msbf_q;
        sample_d       = sample_q;
        out_d          = out_q;
        oe_d           = oe_q;
        conv_valid_d   = 1'b0;
        conv_data_d    = conv_data_q;
        conv_channel_d = conv_channel_q;
        conv_single_d  = conv_single_q;
        abort_d        = 1'b0;

        if (cs_s) begin
            state_d = ST_IDLE;
            out_d   = 1'b0;
            oe_d    = 1'b0;
            last_d  = 1'b0;
            abort_d = cs_rise_s & in_frame_s;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        state_d = ST_WAIT_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT_START: begin
                    if (sclk_rise_s && din_s) begin
                        state_d = ST_CMD;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT_START;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise_s) begin
                        case (cnt_q)
                            4'd0: begin
                                sgl_d = din_s;
                                cnt_d = 4'd1;
                            end
                            4'd1: begin
                                odd_d = din_s;
                                cnt_d = 4'd2;
                            end
                            default: begin
                                msbf_d  = din_s;
                                state_d = ST_NULL_OUT;
                            end
                        endcase
                    end else begin
                        state_d = ST_CMD;
                    end
                end
                ST_NULL_OUT: begin
                    if (sclk_fall_s) begin
                        out_d    = 1'b0;
                        oe_d     = 1'b1;
                        sample_d = select_sample(sgl_q, odd_q, ch0_value, ch1_value);
                        cnt_d    = 4'd11;
                        last_d   = 1'b0;
                        state_d  = ST_DATA_MSB;
                    end else begin
                        state_d = ST_NULL_OUT;
                    end
                end
                ST_DATA_MSB: begin
                    if (sclk_rise_s && last_q) begin
                        state_d        = ST_DONE;
                        last_d         = 1'b0;
                        out_d          = 1'b0;
                        oe_d           = 1'b0;
                        conv_valid_d   = 1'b1;
                        conv_data_d    = sample_q;
                        conv_channel_d = odd_q;
                        conv_single_d  = sgl_q;
                    end else if (sclk_fall_s && !last_q) begin
                        out_d = sample_q[cnt_q];
                        if (cnt_q == 4'd0) begin
                            if (msbf_q) begin
                                last_d = 1'b1;
                            end else begin
                                state_d = ST_DATA_LSB;
                                cnt_d   = 4'd1;
                            end
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end else begin
                        state_d = ST_DATA_MSB;
                    end
                end
                ST_DATA_LSB: begin
                    if (sclk_rise_s && last_q) begin
                        state_d        = ST_DONE;
                        last_d         = 1'b0;
                        out_d          = 1'b0;
                        oe_d           = 1'b0;
                        conv_valid_d   = 1'b1;
                        conv_data_d    = sample_q;
                        conv_channel_d = odd_q;
                        conv_single_d  = sgl_q;
                    end else if (sclk_fall_s && !last_q) begin
                        out_d = sample_q[cnt_q];
                        if (cnt_q == 4'd11) begin
                            last_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = ST_DATA_LSB;
                    end
                end
                ST_DONE: begin
                    out_d   = 1'b0;
                    oe_d    = 1'b0;
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    out_d   = 1'b0;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    assign adc_data_out = out_q;
    assign adc_data_oe  = oe_q;
    assign conv_valid   = conv_valid_q;
    assign conv_data    = conv_data_q;
    assign conv_channel = conv_channel_q;
    assign conv_single  = conv_single_q;
    assign frame_abort  = abort_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Testbench for adc_spi_responder: a behavioural SPI master drives directed
// frames; expected conversions are queued when each frame is issued and a
// monitor compares them whenever conv_valid pulses.
`timescale 1ns/1ps
module tb_adc_spi_responder;

    localparam int HALF = 170;

    logic        clk;
    logic        rst_n;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_din;
    logic        adc_data_out;
    logic        adc_data_oe;
    logic [11:0] ch0_value;
    logic [11:0] ch1_value;
    logic        conv_valid;
    logic [11:0] conv_data;
    logic        conv_channel;
    logic        conv_single;
    logic        frame_abort;

    typedef struct {
        logic [11:0] data;
        logic        ch;
        logic        sgl;
        logic [31:0] rx;
        logic [31:0] oe;
        int          n;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] rx_bits;
    logic [31:0] oe_bits;
    int          rx_cnt;
    int          checks;
    int          errors;
    int          aborts_seen;

    adc_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .adc_cs_n     (adc_cs_n),
        .adc_sclk     (adc_sclk),
        .adc_din      (adc_din),
        .adc_data_out (adc_data_out),
        .adc_data_oe  (adc_data_oe),
        .ch0_value    (ch0_value),
        .ch1_value    (ch1_value),
        .conv_valid   (conv_valid),
        .conv_data    (conv_data),
        .conv_channel (conv_channel),
        .conv_single  (conv_single),
        .frame_abort  (frame_abort)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Queue the expected result of a complete frame (data is hand-computed).
    task automatic push_exp(input logic [11:0] d, input logic ch, input logic sgl,
                            input logic msbf, input int lead);
        exp_t e;
        logic [31:0] w;
        int nd;
        w = 32'd0;
        for (int i = 11; i >= 0; i--) w = {w[30:0], d[i]};
        if (!msbf) begin
            for (int i = 1; i <= 11; i++) w = {w[30:0], d[i]};
        end
        nd = msbf ? 13 : 24;
        e.data = d;
        e.ch   = ch;
        e.sgl  = sgl;
        e.rx   = w;
        e.oe   = (32'd1 << nd) - 32'd1;
        e.n    = lead + 4 + nd;
        exp_q.push_back(e);
    endtask

    // Master frame: lead zeros, start, SGL, ODD, MSBF, then clocks for data.
    // stop_after > 0 truncates the frame; keep_cs leaves CS low at the end.
    task automatic spi_frame(input int lead, input logic sgl, input logic odd,
                             input logic msbf, input int stop_after, input bit keep_cs);
        int total;
        logic b;
        total = lead + 5 + 12 + (msbf ? 0 : 11);
        if (stop_after > 0) total = stop_after;
        rx_bits = 32'd0;
        oe_bits = 32'd0;
        rx_cnt  = 0;
        adc_cs_n = 1'b0;
        #(HALF);
        for (int i = 0; i < total; i++) begin
            if (i < lead)            b = 1'b0;
            else if (i == lead)      b = 1'b1;
            else if (i == lead + 1)  b = sgl;
            else if (i == lead + 2)  b = odd;
            else if (i == lead + 3)  b = msbf;
            else                     b = 1'b0;
            adc_din = b;
            #(HALF);
            adc_sclk = 1'b1;
            rx_bits = {rx_bits[30:0], adc_data_out};
            oe_bits = {oe_bits[30:0], adc_data_oe};
            rx_cnt++;
            #(HALF);
            adc_sclk = 1'b0;
        end
        if (stop_after <= 0) chk("oe_after_last_bit", {31'd0, adc_data_oe}, 32'd0);
        #(HALF);
        if (!keep_cs) begin
            adc_cs_n = 1'b1;
            #(4 * HALF);
        end
    endtask

    // Scoreboard monitor: compare each completed conversion against the queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (conv_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_conv_valid", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("conv_data", {20'd0, conv_data}, {20'd0, mon_e.data});
                    chk("conv_channel", {31'd0, conv_channel}, {31'd0, mon_e.ch});
                    chk("conv_single", {31'd0, conv_single}, {31'd0, mon_e.sgl});
                    chk("miso_bits", rx_bits, mon_e.rx);
                    chk("miso_oe", oe_bits, mon_e.oe);
                    chk("rise_count", rx_cnt, mon_e.n);
                end
            end
            if (frame_abort) aborts_seen++;
        end
    end

    // Hard time limit so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; errors = 0; aborts_seen = 0;
        rx_bits = 32'd0; oe_bits = 32'd0; rx_cnt = 0;
        rst_n = 1'b0; adc_cs_n = 1'b1; adc_sclk = 1'b0; adc_din = 1'b0;
        ch0_value = 12'd0; ch1_value = 12'd0;
        #3;
        #100;
        chk("rst_data_out", {31'd0, adc_data_out}, 32'd0);
        chk("rst_data_oe", {31'd0, adc_data_oe}, 32'd0);
        chk("rst_conv_valid", {31'd0, conv_valid}, 32'd0);
        chk("rst_conv_data", {20'd0, conv_data}, 32'd0);
        chk("rst_frame_abort", {31'd0, frame_abort}, 32'd0);
        rst_n = 1'b1;
        #(4 * HALF);

        // Single-ended CH0
        ch0_value = 12'hA5C;
        push_exp(12'hA5C, 1'b0, 1'b1, 1'b1, 0);
        spi_frame(0, 1'b1, 1'b0, 1'b1, 0, 1'b0);

        // Alternating channels
        ch0_value = 12'h123; ch1_value = 12'h3FF;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                push_exp(12'h123, 1'b0, 1'b1, 1'b1, 0);
                spi_frame(0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
            end else begin
                push_exp(12'h3FF, 1'b1, 1'b1, 1'b1, 0);
                spi_frame(0, 1'b1, 1'b1, 1'b1, 0, 1'b0);
            end
        end

        // Leading zeros: MOSI 0,0,1,1,1,1
        ch1_value = 12'h0F0;
        push_exp(12'h0F0, 1'b1, 1'b1, 1'b1, 2);
        spi_frame(2, 1'b1, 1'b1, 1'b1, 0, 1'b0);

        // MSBF=0: MSB-first then LSB-first tail
        ch0_value = 12'h801;
        push_exp(12'h801, 1'b0, 1'b1, 1'b0, 0);
        spi_frame(0, 1'b1, 1'b0, 1'b0, 0, 1'b0);

        // Differential with saturation
        ch0_value = 12'h100; ch1_value = 12'h300;
        push_exp(12'h000, 1'b0, 1'b0, 1'b1, 0);
        spi_frame(0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        push_exp(12'h200, 1'b1, 1'b0, 1'b1, 0);
        spi_frame(0, 1'b0, 1'b1, 1'b1, 0, 1'b0);

        // Abort after 8 SCLK rises (inside the data phase)
        ch0_value = 12'h555;
        spi_frame(0, 1'b1, 1'b0, 1'b1, 8, 1'b1);
        chk("oe_before_abort", {31'd0, adc_data_oe}, 32'd1);
        adc_cs_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_data_out", {31'd0, adc_data_out}, 32'd0);
        chk("abort_data_oe", {31'd0, adc_data_oe}, 32'd0);
        #(4 * HALF);
        chk("abort_pulses", aborts_seen, 32'd1);
        push_exp(12'h555, 1'b0, 1'b1, 1'b1, 0);
        spi_frame(0, 1'b1, 1'b0, 1'b1, 0, 1'b0);

        // Reset taken mid-data; CS stays low across and after reset
        ch0_value = 12'hABC;
        spi_frame(0, 1'b1, 1'b0, 1'b1, 10, 1'b1);
        chk("oe_before_reset", {31'd0, adc_data_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_data_out", {31'd0, adc_data_out}, 32'd0);
        chk("midrst_data_oe", {31'd0, adc_data_oe}, 32'd0);
        chk("midrst_conv_valid", {31'd0, conv_valid}, 32'd0);
        chk("midrst_conv_data", {20'd0, conv_data}, 32'd0);
        chk("midrst_conv_channel", {31'd0, conv_channel}, 32'd0);
        chk("midrst_conv_single", {31'd0, conv_single}, 32'd0);
        chk("midrst_frame_abort", {31'd0, frame_abort}, 32'd0);
        #60;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            adc_din = 1'b1;
            #(HALF); adc_sclk = 1'b1;
            #(HALF); adc_sclk = 1'b0;
        end
        #(HALF);
        chk("post_rst_silent_oe", {31'd0, adc_data_oe}, 32'd0);
        adc_cs_n = 1'b1;
        #(4 * HALF);
        push_exp(12'hABC, 1'b0, 1'b1, 1'b1, 0);
        spi_frame(0, 1'b1, 1'b0, 1'b1, 0, 1'b0);

        #(4 * HALF);
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("total_aborts", aborts_seen, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Synthesizable SPI responder that emulates a 2-channel, 12-bit MCP3202-style ADC. It answers the existing SPI ADC master on the same four-wire bus (CS, SCLK, MOSI, MISO). Channel values come from on-chip sources such as test registers, a pattern generator or a sensor model. It is used for on-board loopback and for closed-loop simulation of the ADC master without the physical converter.

## Interface
- SYNC_STAGES, 2: synchronizer depth for `adc_cs_n`, `adc_sclk` and `adc_din`; legal values are 2 to 3.
- clk  input  1  system clock, 50 MHz nominal.
- rst_n  input  1  asynchronous active-low reset.
- adc_cs_n  input  1  chip select from the master, active low, asynchronous to `clk`.
- adc_sclk  input  1  SPI clock from the master, mode 0 (idle low), asynchronous to `clk`.
- adc_din  input  1  MOSI command bits.
- adc_data_out  output  1  MISO toward the master.
- adc_data_oe  output  1  high while `adc_data_out` carries the null bit or data; low means high-Z at the pad.
- ch0_value  input  12  CH0 analog value.
- ch1_value  input  12  CH1 analog value.
- conv_valid  output  1  one-cycle pulse when a frame completes.
- conv_data  output  12  value returned in the last conversion.
- conv_channel  output  1  ODD/SIGN bit of the last command.
- conv_single  output  1  SGL/DIFF bit of the last command.
- frame_abort  output  1  one-cycle pulse when CS rises mid-frame after the start bit.

## Operation
- The bus inputs pass through a SYNC_STAGES flop chain. A registered previous value then produces `sclk_rise`, `sclk_fall` and `cs_rise` pulses in the `clk` domain.
- States:
  - IDLE: CS is high.
  - WAIT_START: CS is low, no start bit yet. On each `sclk_rise`, if the synchronized `adc_din` is 1 go to CMD; leading zeros are ignored.
  - CMD: capture SGL, ODD and MSBF on the next three `sclk_rise` events. After MSBF go to NULL_OUT.
  - NULL_OUT: on the next `sclk_fall`, drive 0, assert `adc_data_oe`, latch the sample value and go to DATA_MSB.
  - DATA_MSB: on each following `sclk_fall`, drive B11 down to B0.
    - After B0, if MSBF=1, go to DONE on the next `sclk_rise`.
    - After B0, if MSBF=0, go to DATA_LSB.
  - DATA_LSB: on each following `sclk_fall`, drive B1 up to B11. Go to DONE on the `sclk_rise` that follows B11.
  - DONE: drive 0 with `adc_data_oe` low until CS rises, then go to IDLE.
- From every state, synchronized CS high forces IDLE. It also forces `adc_data_out`=0 and `adc_data_oe`=0.
- Sample value latch rules:
  - SGL=1, ODD=0: `ch0_value`.
  - SGL=1, ODD=1: `ch1_value`.
  - SGL=0, ODD=0: ch0−ch1, saturated at 0. Compute in 13 bits; if bit 12 is set the result is 0.
  - SGL=0, ODD=1: ch1−ch0, saturated at 0.
  - The value is frozen for the rest of the frame. Later changes on `ch*_value` do not alter the bits already being shifted out.
- `conv_valid`, `conv_data`, `conv_channel` and `conv_single` update together in the cycle the DONE transition is taken. They hold until the next completed frame.
- `frame_abort` pulses when `cs_rise` occurs in CMD, NULL_OUT, DATA_MSB or DATA_LSB. It does not pulse in WAIT_START. No `conv_valid` is issued for an aborted frame.
- A `cs_rise` in the same cycle as an SCLK edge takes priority: the edge is ignored.

## Timing
- Reset values: `adc_data_out`=0, `adc_data_oe`=0, `conv_valid`=0, `conv_data`=0, `conv_channel`=0, `conv_single`=0, `frame_abort`=0. The state machine resets to IDLE.
- Reset mid-frame returns to IDLE immediately. The responder then waits for CS high followed by CS low before it responds again.
- Input-to-edge-pulse latency is SYNC_STAGES+1 clk cycles. `adc_data_out` changes one cycle after `sclk_fall`. Total delay from the pad SCLK fall to MISO valid is at most SYNC_STAGES+2 cycles, i.e. 80 ns at 50 MHz with the default.
- SCLK high and low phases must each be at least SYNC_STAGES+3 clk cycles. The 1 MHz master (500 ns per phase) meets this with margin.
- Frame bit numbering by master rising edge, when no leading zeros are sent:
  - Edge 0: start bit.
  - Edges 1–3: SGL, ODD, MSBF.
  - Edge 4: null bit.
  - Edges 5–16: B11..B0.
  - Edges 17–27: B1..B11, only when MSBF=0.

## Test plan
- Single-ended CH0: `ch0_value`=12'hA5C, command 1,1,0,1. Response: MISO reads 0 at edge 4, then 1010_0101_1100 on edges 5–16. One `conv_valid` pulse with `conv_data`=A5C, `conv_channel`=0, `conv_single`=1.
- Alternating channels with the real master connected: `ch0_value`=12'h123, `ch1_value`=12'h3FF. Response: `dial_value`=123 and `cds_value`=3FF after two frames. Repeat 10 frames with no mismatch.
- Leading zeros: MOSI sends 0,0,1,1,1,1 with `ch1_value`=12'h0F0. Response: start is recognized on the third rise and the data returned is 0F0.
- MSBF=0 on CH0 with `ch0_value`=12'h801. Response: MSB-first 1000_0000_0001, then B1..B11 as 0,0,0,0,0,0,0,0,0,0,1. `adc_data_oe` drops after B11.
- Differential: `ch0_value`=12'h100, `ch1_value`=12'h300.
  - ODD=0 returns 000.
  - ODD=1 returns 200.
- Abort and reset:
  - CS rises after 8 SCLK: `frame_abort` pulses once, no `conv_valid`, MISO=0 and `adc_data_oe`=0 within SYNC_STAGES+2 cycles. The next frame returns the correct value.
  - `rst_n` asserted mid-DATA_MSB: every output returns to its reset value.
